// File: rtl/simple_computer_pkg.sv
// Shared definitions for the simple computer: instruction layout, opcodes
// and the program-loader state encoding.
package simple_computer_pkg;

    localparam int unsigned INSTR_W = 8;
    localparam int unsigned OPC_W   = 3;
    localparam int unsigned OPC_LSB = INSTR_W - OPC_W;

    localparam logic [OPC_W-1:0] OP_NOP  = 3'b000;
    localparam logic [OPC_W-1:0] OP_STOP = 3'b001;
    localparam logic [OPC_W-1:0] OP_LOAD = 3'b010;
    localparam logic [OPC_W-1:0] OP_SET  = 3'b011;
    localparam logic [OPC_W-1:0] OP_ADD  = 3'b100;
    localparam logic [OPC_W-1:0] OP_MULT = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FINISH,
        S_DONE,
        S_ERR
    } load_state_t;

    function automatic logic opcode_legal(input logic [OPC_W-1:0] op);
        return op <= OP_MULT;
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Streams instructions into program memory from address 0 and closes the
// program with a STOP word in the slot reserved at the end.
module prog_loader #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned INSTR_W = simple_computer_pkg::INSTR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_opcode,
    input  logic [INSTR_W-4:0]   in_operand,
    input  logic                 finish,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [INSTR_W-1:0]   mem_wdata,
    output logic                 done,
    output logic                 error,
    output logic [ADDR_W:0]      count
);
    import simple_computer_pkg::*;

    localparam int unsigned OPND_W = INSTR_W - OPC_W;

    load_state_t          state_q, state_d;
    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic                 full;
    logic                 accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        count_d     = count_q;

        full     = (wr_ptr_q == '1);
        in_ready = (state_q == S_LOAD) && !full;
        accept   = in_valid && in_ready && !start;

        if (start) begin
            state_d  = S_LOAD;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    // An illegal opcode aborts even if finish arrives with it.
                    if (accept && !opcode_legal(in_opcode)) begin
                        state_d = S_ERR;
                    end else begin
                        if (accept) begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = wr_ptr_q;
                            mem_wdata_d = {in_opcode, in_operand};
                            wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
                        end
                        if (finish) state_d = S_FINISH;
                    end
                end
                S_FINISH: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wr_ptr_q;
                    mem_wdata_d = {OP_STOP, {OPND_W{1'b0}}};
                    count_d     = {1'b0, wr_ptr_q} + (ADDR_W+1)'(1);
                    state_d     = S_DONE;
                end
                default: ;
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERR);

endmodule
